// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared state encoding, widths and control bundle for the hazard controller
package pipeline_hazard_ctrl_pkg;
  localparam int REG_NUM_WIDTH = 5;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;
  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_bubble;
  } ctrl_t;
  localparam ctrl_t CTRL_LU    = ctrl_t'(4'b1101);
  localparam ctrl_t CTRL_FLUSH = ctrl_t'(4'b0011);
  localparam ctrl_t CTRL_MEM   = ctrl_t'(4'b1100);
endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// pipeline_hazard_ctrl_hazard_detect: combinational load-use match between the load in EX and the sources in ID
module pipeline_hazard_ctrl_hazard_detect #(
  parameter int REG_NUM_WIDTH = 5
) (
  input  logic                     i_mem_read,
  input  logic [REG_NUM_WIDTH-1:0] i_rd,
  input  logic [REG_NUM_WIDTH-1:0] i_rs,
  input  logic [REG_NUM_WIDTH-1:0] i_rt,
  input  logic                     i_uses_rt,
  output logic                     o_lu_hit
);
  assign o_lu_hit = i_mem_read && (i_rd != '0) && ((i_rd == i_rs) || (i_uses_rt && (i_rd == i_rt)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/bubble sequencing for the 5-stage pipe; HAZARD_PERF_CNT_EN adds stall/flush counters
module pipeline_hazard_ctrl #(
  parameter int REG_NUM_WIDTH   = pipeline_hazard_ctrl_pkg::REG_NUM_WIDTH,
  parameter int LU_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES    = 1,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_NUM_WIDTH-1:0] ifid_rs,
  input  logic [REG_NUM_WIDTH-1:0] ifid_rt,
  input  logic                     ifid_uses_rt,
  input  logic                     idex_mem_read,
  input  logic [REG_NUM_WIDTH-1:0] idex_rd,
  input  logic                     branch_taken,
  input  logic                     dmem_busy,
  output logic                     pc_stall,
  output logic                     ifid_stall,
  output logic                     ifid_flush,
  output logic                     idex_bubble,
  output logic [1:0]               ctrl_state,
  output logic [CNT_WIDTH-1:0]     stall_cnt,
  output logic [CNT_WIDTH-1:0]     flush_cnt
);
  import pipeline_hazard_ctrl_pkg::*;
  localparam logic [2:0] LU_RELOAD = 3'(LU_STALL_CYCLES - 1);
  localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);
  state_t     r_state, w_next;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_pend, w_pend_nxt;
  logic       w_lu_hit;
  ctrl_t      w_ctrl, w_out;
  pipeline_hazard_ctrl_hazard_detect #(.REG_NUM_WIDTH(REG_NUM_WIDTH)) u_detect (
    .i_mem_read (idex_mem_read),
    .i_rd       (idex_rd),
    .i_rs       (ifid_rs),
    .i_rt       (ifid_rt),
    .i_uses_rt  (ifid_uses_rt),
    .o_lu_hit   (w_lu_hit)
  );
  // Next state and controls; a memory freeze defers any flush (including the rest of a flush sequence) until it ends
  always_comb begin
    w_ctrl     = '0;
    w_next     = r_state;
    w_cnt_nxt  = r_cnt;
    w_pend_nxt = r_pend;
    if (dmem_busy) begin
      w_ctrl     = CTRL_MEM;
      w_next     = ST_MEM_WAIT;
      w_pend_nxt = r_pend | branch_taken | (r_state == ST_FLUSH);
    end else if (branch_taken || r_pend) begin
      w_ctrl     = CTRL_FLUSH;
      w_pend_nxt = 1'b0;
      w_cnt_nxt  = FL_RELOAD;
      w_next     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else if (r_state == ST_FLUSH) begin
      w_ctrl    = CTRL_FLUSH;
      w_cnt_nxt = r_cnt - 3'd1;
      w_next    = (r_cnt <= 3'd1) ? ST_RUN : ST_FLUSH;
    end else if (r_state == ST_LU_STALL) begin
      w_ctrl    = CTRL_LU;
      w_cnt_nxt = r_cnt - 3'd1;
      w_next    = (r_cnt <= 3'd1) ? ST_RUN : ST_LU_STALL;
    end else if (w_lu_hit) begin
      w_ctrl    = CTRL_LU;
      w_cnt_nxt = LU_RELOAD;
      w_next    = (LU_STALL_CYCLES > 1) ? ST_LU_STALL : ST_RUN;
    end else begin
      w_next = ST_RUN;
    end
  end
  // State, sequence counter and deferred-flush flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
    end
  end
  assign w_out       = rst ? w_ctrl : '0;
  assign pc_stall    = w_out.pc_stall;
  assign ifid_stall  = w_out.ifid_stall;
  assign ifid_flush  = w_out.ifid_flush;
  assign idex_bubble = w_out.idex_bubble;
  assign ctrl_state  = r_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt, r_flush_cnt;
  // Saturating counts of stalled and flushed cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_out.ifid_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_out.ifid_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 5-stage pipeline. Generates the stall (dHazard) and flush (cHazard) controls for the IF/ID register, the PC hold, and bubble insertion into ID/EX. It sequences multi-cycle load-use stalls, branch flushes and data-memory wait freezes, and arbitrates between them when they coincide. Sits beside the IF/ID and ID/EX registers and is driven by decoded register numbers from IF/ID plus status from EX/MEM.

Parameters:
REG_NUM_WIDTH, 5, register-number width
LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
FLUSH_CYCLES, 1, cycles cHazard is held per taken branch (1..7)
CNT_WIDTH, 32, perf counter width (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
ifid_rs  in  REG_NUM_WIDTH  source reg RS of the instruction in IF/ID
ifid_rt  in  REG_NUM_WIDTH  source reg RT of the instruction in IF/ID
ifid_uses_rt  in  1  instruction in ID actually reads RT
idex_mem_read  in  1  instruction in EX is a load
idex_rd  in  REG_NUM_WIDTH  destination reg of the instruction in EX
branch_taken  in  1  EX resolved a taken branch/jump (one-cycle pulse)
dmem_busy  in  1  data memory not ready; freeze the whole pipe
pc_stall  out  1  hold PC
ifid_stall  out  1  dHazard to IF/ID (hold contents)
ifid_flush  out  1  cHazard to IF/ID (zero contents)
idex_bubble  out  1  load NOP into ID/EX
ctrl_state  out  2  current FSM state (RUN=0, LU_STALL=1, FLUSH=2, MEM_WAIT=3)
stall_cnt  out  CNT_WIDTH  stall-cycle count (optional feature)
flush_cnt  out  CNT_WIDTH  flush-cycle count (optional feature)

Behaviour:
- Reset (rst low, asynchronous): state=RUN, counters cleared, pending_flush=0, all control outputs 0, stall_cnt=flush_cnt=0.
- Load-use detect, lu_hit = idex_mem_read && idex_rd!=0 && (idex_rd==ifid_rs || (ifid_uses_rt && idex_rd==ifid_rt)). Register 0 never hazards.
- Outputs are combinational from state and inputs; state and counters are registered.
- Priority each cycle: dmem_busy > branch_taken/pending_flush > FLUSH > lu_hit/LU_STALL.
- RUN:
  - dmem_busy: pc_stall=ifid_stall=1, idex_bubble=0. Next state MEM_WAIT.
  - branch_taken: ifid_flush=1, idex_bubble=1. If FLUSH_CYCLES>1, next FLUSH with cnt=FLUSH_CYCLES-1; else stay RUN.
  - lu_hit: pc_stall=ifid_stall=idex_bubble=1. If LU_STALL_CYCLES>1, next LU_STALL with cnt=LU_STALL_CYCLES-1.
- LU_STALL: same outputs as the lu_hit case. Decrement cnt; move to RUN when cnt reaches 1. branch_taken aborts the stall: flush outputs are driven and the FSM follows the RUN branch path.
- FLUSH: ifid_flush=idex_bubble=1. Decrement cnt; move to RUN at 1. A new branch_taken reloads cnt=FLUSH_CYCLES-1.
- MEM_WAIT: pc_stall=ifid_stall=1. Any branch_taken arriving here sets pending_flush. Stay while dmem_busy. When dmem_busy drops:
  - pending_flush: flush outputs this cycle, clear pending_flush, and follow the RUN branch path.
  - otherwise: evaluate lu_hit as in RUN.
- ifid_flush and ifid_stall are never both 1. Flush wins, except under dmem_busy, where the flush is deferred.
- Async reset mid-stall or mid-flush returns to RUN immediately with outputs 0.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: stall_cnt increments each cycle ifid_stall=1; flush_cnt increments each cycle ifid_flush=1. Both saturate at all-ones.
- Undefined: both ports tied to 0 and no counter flops are built.

Decomposition:
- Shared package: state enum, REG_NUM_WIDTH, control-bundle typedef {pc_stall, ifid_stall, ifid_flush, idex_bubble}.
- One sub-module, hazard_detect: purely combinational lu_hit logic, reused later for forwarding checks.

Test Plan:
- idex_mem_read=1, idex_rd=5, ifid_rs=5, LU_STALL_CYCLES=1 -> pc_stall=ifid_stall=idex_bubble=1 for exactly 1 cycle, then 0.
- idex_rd=0, idex_mem_read=1, ifid_rs=0 -> no stall. Same case with ifid_rt=5, ifid_uses_rt=0, idex_rd=5 -> no stall.
- branch_taken pulse with FLUSH_CYCLES=2 -> ifid_flush=idex_bubble=1 for 2 cycles, ctrl_state RUN->FLUSH->RUN.
- branch_taken and lu_hit in the same cycle -> ifid_flush=1, ifid_stall=0.
- dmem_busy high for 3 cycles with branch_taken pulse in cycle 2 -> stall for 3 cycles, then ifid_flush=1 on the first cycle after busy drops.
- rst low during LU_STALL (LU_STALL_CYCLES=3) -> all outputs 0 immediately and ctrl_state=0. With HAZARD_PERF_CNT_EN, stall_cnt=0.
